// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the seven-segment scan driver: the hex-to-segment
// table, the blank values for SEG/AN, and the widest supported display.
// Segment encoding is active-low {g,f,e,d,c,b,a}. The decimal point is
// added separately by the driver and is always kept off.
package seg7_pkg;

  localparam int MAX_DIG = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Index is the nibble value 0..F; entries are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Combinational hex digit to seven-segment decoder (active-low).
// Ports:
//   nibble_i  4-bit hex digit
//   seg_o     7-bit segment pattern {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Captures the value published on the LED data strobe and shows it as hex
// digits on a multiplexed, active-low seven-segment display. A prescaler sets
// how long each digit is driven; new values only take effect at the start of
// a frame so a frame never mixes digits of two values.
// Optional feature: define SEG_LZ_BLANK_EN to blank leading zero digits.
// Parameters:
//   WIDTH    displayed data width, multiple of 4, 4..32 (NDIG = WIDTH/4)
//   CLK_DIV  clock cycles per digit slot, >= 2
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset
//   led_data_i  value to display
//   led_we_i    one-cycle strobe qualifying led_data_i
//   seg_o       segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   an_o        digit anodes, active-low, an_o[0] = least significant nibble
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 100000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] led_data_i,
  input  logic             led_we_i,
  output logic [7:0]       seg_o,
  output logic [7:0]       an_o
);

  localparam int NDIG = WIDTH / 4;
  localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_DIV - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NDIG - 1);

  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;

  logic             tick;
  logic             frameEnd;
  logic [3:0]       curNibble;
  logic [6:0]       hexSeg;

  // Next-state for prescaler, digit index and the shadow/display registers.
  // On the frame boundary a same-cycle strobe bypasses the shadow so it is
  // visible on this very edge instead of one frame later.
  always_comb begin
    tick     = (pcnt_q == PCNT_LAST);
    frameEnd = tick && (idx_q == IDX_LAST);

    pcnt_d = tick ? '0 : pcnt_q + PW'(1);

    idx_d = idx_q;
    if (frameEnd) begin
      idx_d = 3'd0;
    end else if (tick) begin
      idx_d = idx_q + 3'd1;
    end

    shadow_d  = led_we_i ? led_data_i : shadow_q;
    pending_d = pending_q | led_we_i;
    disp_d    = disp_q;
    if (frameEnd) begin
      pending_d = 1'b0;
      if (led_we_i) begin
        disp_d = led_data_i;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end
  end

  // Nibble selected by the upcoming digit index from the upcoming display value.
  always_comb begin
    curNibble = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_d == 3'(i)) begin
        curNibble = disp_d[4*i +: 4];
      end
    end
  end

  seg7_hex_decode uDecode (
    .nibble_i (curNibble),
    .seg_o    (hexSeg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [2:0] topNibble;

  // Index of the most significant non-zero nibble; stays 0 for a zero value
  // so digit 0 is never blanked.
  always_comb begin
    topNibble = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (disp_d[4*i +: 4] != 4'h0) begin
        topNibble = 3'(i);
      end
    end
  end
`endif

  // Output registers only change on a tick.
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = {1'b1, hexSeg};
      an_d  = ~(8'h01 << idx_d);
`ifdef SEG_LZ_BLANK_EN
      if (idx_d > topNibble) begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end
`endif
    end
  end

  // Reset leaves idx at the last digit so the first tick is a frame boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt_q    <= '0;
      idx_q     <= IDX_LAST;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream consumer of the CPU's `LedData` output: captures the 32-bit value the core publishes and shows it as eight hex digits on a multiplexed, active-low seven-segment display (`SEG`/`AN`). A prescaler sets the digit scan rate. New values are applied only at frame boundaries, so a frame never shows digits from two different values.

## Interface
- `WIDTH`, 32, data width; must be a multiple of 4, from 4 to 32; number of digits `NDIG` = `WIDTH/4`
- `CLK_DIV`, 100000, clock cycles per digit slot; must be ≥ 2
- `clk` in 1 system clock, rising edge
- `rst` in 1 reset, asynchronous, active-high
- `led_data` in WIDTH value to display
- `led_we` in 1 one-cycle strobe; `led_data` is valid in this cycle
- `SEG` out 8 segments, active-low: {dp,g,f,e,d,c,b,a}
- `AN` out 8 digit anodes, active-low; `AN[i]` selects nibble i (`AN[0]` is the least significant nibble)

## Operation
- `shadow` (WIDTH bits): loaded from `led_data` on `led_we`; sets `pending`. Back-to-back strobes: the last one wins.
- `disp` (WIDTH bits): the value actually scanned.
- Prescaler `pcnt`: counts 0..`CLK_DIV`-1 and wraps. `tick` = (`pcnt` == `CLK_DIV`-1).
- Digit index `idx`: 3 bits, counts 0..`NDIG`-1 and advances on `tick`.
- Frame boundary = `tick` while `idx` == `NDIG`-1. At the boundary, `idx` goes to 0, and:
  - If `led_we` is high in the same cycle, `disp` takes `led_data` directly (bypass), and `shadow` also takes it. `pending` clears.
  - Otherwise, if `pending` is set, `disp` takes `shadow` and `pending` clears.
  - Otherwise `disp` holds.
- Outputs on each `tick`, computed for the new `idx` and the new `disp`:
  - `AN` = one-hot-low at the new `idx`.
  - `SEG` = hex decode of `disp[4*idx+3 : 4*idx]`, with dp held at 1 (off).
  - `AN` bits at positions ≥ `NDIG` are always 1.
- Hex table (`SEG` values): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- Reset values: `SEG`=8'hFF, `AN`=8'hFF, `pcnt`=0, `idx`=`NDIG`-1, `shadow`=0, `disp`=0, `pending`=0.
- The first tick comes `CLK_DIV` cycles after reset release. That tick is a frame boundary, so the first frame starts at digit 0 and applies any pending value.
- `SEG` and `AN` are registered and change only on tick edges. Each digit is driven for exactly `CLK_DIV` cycles; a full frame is `NDIG`·`CLK_DIV` cycles.
- Latency from `led_we` to display is 1 to `NDIG`·`CLK_DIV` cycles, depending on where the frame is. The bypass case takes effect on the same edge as the strobe.
- Asserting `rst` mid-frame blanks the outputs immediately (asynchronous) and discards `pending`.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking. When scanned digit i lies above the most significant non-zero nibble of `disp`, `AN`[i] stays 1 for that slot and `SEG`=FF. Digit 0 is never blanked, so `disp`=0 shows a single "0". The blanking is computed from `disp` after the boundary update.
- `SEG_LZ_BLANK_EN` not defined: all `NDIG` digits are always shown.

## Structure
- Package `seg7_pkg`:
  - hex-to-segment constant table
  - `SEG_OFF` (8'hFF) and `AN_OFF` (8'hFF)
  - `MAX_DIG` = 8
- Sub-module `seg7_hex_decode`: combinational, 4-bit in, 7-bit active-low out. It is instantiated once and fed by the nibble mux.

## Test plan
All scenarios use `CLK_DIV`=4 and `WIDTH`=32.
- Reset, then 40 idle cycles → `SEG`=FF and `AN`=FF until the first tick. Afterwards all digits show C0, and `AN` walks FE, FD, FB … 7F, one step every 4 cycles.
- `led_we` with 32'h1234ABCD in mid-frame → the current frame is unchanged. From the next boundary the digits read D(A1), C(C6), B(83), A(88), 4(99), 3(B0), 2(A4), 1(F9).
- Two strobes in the same frame, 32'h11111111 then 32'h0000000F → only 8E, C0, C0 … is ever displayed.
- Strobe exactly on the boundary cycle with 32'hFFFFFFFF → digit 0 shows 8E in the same tick, with no extra frame of latency.
- `rst` pulse in mid-frame with a write pending → `SEG`/`AN` go to FF asynchronously, and the next frame shows zeros.
- `SEG_LZ_BLANK_EN` defined, 32'h000000A5 → only `AN`=FE (92) and FD (88) go low; slots 2–7 keep `AN`=FF and `SEG`=FF.
